// File: rtl/vga_mode_pkg.sv
// Shared mode indices, one-hot pixel-mux encodings and sequencer FSM states.
// Pure definitions: no latency, no backpressure.
package vga_mode_pkg;

    localparam int NUM_MODES = 6;

    localparam logic [2:0] MODE_WHITE   = 3'd0;
    localparam logic [2:0] MODE_BLACK   = 3'd1;
    localparam logic [2:0] MODE_RED     = 3'd2;
    localparam logic [2:0] MODE_GREEN   = 3'd3;
    localparam logic [2:0] MODE_MONITOR = 3'd4;
    localparam logic [2:0] MODE_CHAR    = 3'(NUM_MODES - 1);

    localparam logic [5:0] ONEHOT_WHITE   = 6'b000_001;
    localparam logic [5:0] ONEHOT_BLACK   = 6'b000_010;
    localparam logic [5:0] ONEHOT_RED     = 6'b000_100;
    localparam logic [5:0] ONEHOT_GREEN   = 6'b001_000;
    localparam logic [5:0] ONEHOT_MONITOR = 6'b010_000;
    localparam logic [5:0] ONEHOT_CHAR    = 6'b100_000;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_PEND  = 2'd1,
        S_BLANK = 2'd2
    } seq_state_t;

    // Out-of-range indices fall back to WHITE so the mux never sees a non-one-hot word.
    function automatic logic [5:0] idx_to_onehot(input logic [2:0] idx);
        case (idx)
            MODE_WHITE:   return ONEHOT_WHITE;
            MODE_BLACK:   return ONEHOT_BLACK;
            MODE_RED:     return ONEHOT_RED;
            MODE_GREEN:   return ONEHOT_GREEN;
            MODE_MONITOR: return ONEHOT_MONITOR;
            MODE_CHAR:    return ONEHOT_CHAR;
            default:      return ONEHOT_WHITE;
        endcase
    endfunction

    function automatic logic [2:0] mode_inc(input logic [2:0] idx);
        return (idx >= MODE_CHAR) ? MODE_WHITE : idx + 3'd1;
    endfunction

    function automatic logic [2:0] mode_dec(input logic [2:0] idx);
        return (idx == MODE_WHITE) ? MODE_CHAR : idx - 3'd1;
    endfunction

endpackage

// File: rtl/vga_mode_dwell_timer.sv
// Counts enabled frame pulses up to DWELL_FRAMES-1; tc is combinational from the count.
// Latency: count updates on the edge after en; no backpressure, clr dominates en.
module vga_mode_dwell_timer #(
    parameter int DWELL_FRAMES = 120
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int DW = $clog2(DWELL_FRAMES);

    logic [DW-1:0] cnt;

    assign tc = (cnt == DW'(DWELL_FRAMES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + DW'(1);
        end
    end

endmodule

// File: rtl/vga_mode_sequencer.sv
// Frame-synchronous VGA mode selector; optional one-frame BLACK blank on switch (VGA_MODE_BLANK_EN).
// Latency: requests reach target/pending next cycle, applied one cycle after a frame_start.
// Backpressure: none; requests are pulses folded into target at any time.
module vga_mode_sequencer
    import vga_mode_pkg::*;
#(
    parameter int DWELL_FRAMES = 120
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       next_req,
    input  logic       prev_req,
    input  logic       sel_valid,
    input  logic [2:0] sel_idx,
    input  logic       auto_en,
    output logic [5:0] VGA_state,
    output logic [2:0] mode_idx,
    output logic       pending
);

    seq_state_t state;
    logic [2:0] target;
    logic [2:0] tgt_nxt;
    logic [2:0] mode_nxt;
    logic       enter_blank;
    logic       man_acc;
    logic       sel_ok;
    logic       dwell_en;
    logic       dwell_tc;
    logic       auto_fire;

    assign sel_ok    = sel_valid && (sel_idx <= MODE_CHAR);
    assign man_acc   = sel_ok || (next_req ^ prev_req);
    assign dwell_en  = frame_start && auto_en && !pending;
    assign auto_fire = dwell_en && dwell_tc && !man_acc;

    vga_mode_dwell_timer #(
        .DWELL_FRAMES (DWELL_FRAMES)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (man_acc || !auto_en),
        .en    (dwell_en),
        .tc    (dwell_tc)
    );

    // Auto-advance steps from the displayed mode, manual steps from the accumulated target.
    always_comb begin
        tgt_nxt = target;
        if (sel_ok) begin
            tgt_nxt = sel_idx;
        end else if (next_req && !prev_req) begin
            tgt_nxt = mode_inc(target);
        end else if (prev_req && !next_req) begin
            tgt_nxt = mode_dec(target);
        end else if (auto_fire) begin
            tgt_nxt = mode_inc(mode_idx);
        end
    end

    always_comb begin
        mode_nxt    = mode_idx;
        enter_blank = 1'b0;
        case (state)
            S_PEND: begin
                if (frame_start) begin
`ifdef VGA_MODE_BLANK_EN
                    if (target != MODE_BLACK) begin
                        mode_nxt    = MODE_BLACK;
                        enter_blank = 1'b1;
                    end else begin
                        mode_nxt = target;
                    end
`else
                    mode_nxt = target;
`endif
                end
            end
            S_BLANK: begin
                if (frame_start) begin
                    mode_nxt = target;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_RUN;
            target    <= MODE_WHITE;
            mode_idx  <= MODE_WHITE;
            VGA_state <= ONEHOT_WHITE;
            pending   <= 1'b0;
        end else begin
            target    <= tgt_nxt;
            mode_idx  <= mode_nxt;
            VGA_state <= idx_to_onehot(mode_nxt);
            pending   <= (tgt_nxt != mode_nxt);
            case (state)
                S_BLANK: begin
                    if (frame_start) begin
                        state <= (tgt_nxt != mode_nxt) ? S_PEND : S_RUN;
                    end
                end
                default: begin
                    if (enter_blank) begin
                        state <= S_BLANK;
                    end else begin
                        state <= (tgt_nxt != mode_nxt) ? S_PEND : S_RUN;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// Directed bench for vga_mode_sequencer with DWELL_FRAMES = 4.
module tb_vga_mode_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_start;
    logic       next_req;
    logic       prev_req;
    logic       sel_valid;
    logic [2:0] sel_idx;
    logic       auto_en;
    logic [5:0] VGA_state;
    logic [2:0] mode_idx;
    logic       pending;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vga_mode_sequencer #(
        .DWELL_FRAMES (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .next_req    (next_req),
        .prev_req    (prev_req),
        .sel_valid   (sel_valid),
        .sel_idx     (sel_idx),
        .auto_en     (auto_en),
        .VGA_state   (VGA_state),
        .mode_idx    (mode_idx),
        .pending     (pending)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic n, input logic p, input logic s,
                       input logic [2:0] idx, input logic f);
        next_req    = n;
        prev_req    = p;
        sel_valid   = s;
        sel_idx     = idx;
        frame_start = f;
        tick();
        next_req    = 1'b0;
        prev_req    = 1'b0;
        sel_valid   = 1'b0;
        sel_idx     = 3'd0;
        frame_start = 1'b0;
    endtask

    task automatic fs_pulse;
        req(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    endtask

    task automatic chk(input string tag, input logic [5:0] vs_exp,
                       input logic [2:0] mi_exp, input logic p_exp);
        checks++;
        assert (VGA_state === vs_exp) else begin
            failures++;
            $error("FAIL %s VGA_state observed=%b expected=%b", tag, VGA_state, vs_exp);
        end
        checks++;
        assert (mode_idx === mi_exp) else begin
            failures++;
            $error("FAIL %s mode_idx observed=%0d expected=%0d", tag, mode_idx, mi_exp);
        end
        checks++;
        assert (pending === p_exp) else begin
            failures++;
            $error("FAIL %s pending observed=%b expected=%b", tag, pending, p_exp);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        frame_start = 1'b0;
        next_req    = 1'b0;
        prev_req    = 1'b0;
        sel_valid   = 1'b0;
        sel_idx     = 3'd0;
        auto_en     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("reset", 6'b000001, 3'd0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            fs_pulse();
            chk("idle_fs", 6'b000001, 3'd0, 1'b0);
        end

`ifdef VGA_MODE_BLANK_EN
        req(1'b0, 1'b0, 1'b1, 3'd2, 1'b0);
        chk("blk_sel2_pend", 6'b000001, 3'd0, 1'b1);
        fs_pulse();
        chk("blk_black", 6'b000010, 3'd1, 1'b1);
        tick();
        chk("blk_hold", 6'b000010, 3'd1, 1'b1);
        fs_pulse();
        chk("blk_exit", 6'b000100, 3'd2, 1'b0);

        req(1'b0, 1'b0, 1'b1, 3'd3, 1'b0);
        fs_pulse();
        chk("blk_black2", 6'b000010, 3'd1, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("blk_rst", 6'b000001, 3'd0, 1'b0);
        fs_pulse();
        chk("blk_rst_discard", 6'b000001, 3'd0, 1'b0);

        req(1'b0, 1'b0, 1'b1, 3'd1, 1'b0);
        fs_pulse();
        chk("blk_skip_black", 6'b000010, 3'd1, 1'b0);
`else
        req(1'b0, 1'b0, 1'b1, 3'd5, 1'b0);
        chk("sel5_pend", 6'b000001, 3'd0, 1'b1);
        fs_pulse();
        chk("sel5_apply", 6'b100000, 3'd5, 1'b0);
        req(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        chk("wrap_pend", 6'b100000, 3'd5, 1'b1);
        fs_pulse();
        chk("wrap_apply", 6'b000001, 3'd0, 1'b0);

        req(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        req(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        req(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        chk("acc_pend", 6'b000001, 3'd0, 1'b1);
        req(1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        chk("both_pend", 6'b000001, 3'd0, 1'b1);
        fs_pulse();
        chk("acc_apply", 6'b000010, 3'd1, 1'b0);
        req(1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        chk("both_idle", 6'b000010, 3'd1, 1'b0);

        req(1'b0, 1'b0, 1'b1, 3'd7, 1'b0);
        chk("sel7_ignored", 6'b000010, 3'd1, 1'b0);
        req(1'b1, 1'b0, 1'b1, 3'd7, 1'b0);
        chk("sel7_next", 6'b000010, 3'd1, 1'b1);
        req(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        chk("cancel", 6'b000010, 3'd1, 1'b0);
        fs_pulse();
        chk("cancel_fs", 6'b000010, 3'd1, 1'b0);

        req(1'b0, 1'b0, 1'b1, 3'd4, 1'b1);
        chk("sel4_with_fs", 6'b000010, 3'd1, 1'b1);
        fs_pulse();
        chk("sel4_apply", 6'b010000, 3'd4, 1'b0);

        auto_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fs_pulse();
            chk("dwell", 6'b010000, 3'd4, 1'b0);
        end
        fs_pulse();
        chk("auto_tc", 6'b010000, 3'd4, 1'b1);
        fs_pulse();
        chk("auto_apply", 6'b100000, 3'd5, 1'b0);

        fs_pulse();
        fs_pulse();
        chk("dwell_mid", 6'b100000, 3'd5, 1'b0);
        req(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        chk("mid_next", 6'b100000, 3'd5, 1'b1);
        fs_pulse();
        chk("mid_apply", 6'b000001, 3'd0, 1'b0);
        fs_pulse();
        fs_pulse();
        chk("dwell_restart", 6'b000001, 3'd0, 1'b0);
        fs_pulse();
        chk("dwell_restart3", 6'b000001, 3'd0, 1'b0);
        fs_pulse();
        chk("auto_tc2", 6'b000001, 3'd0, 1'b1);
        fs_pulse();
        chk("auto_apply2", 6'b000010, 3'd1, 1'b0);
        auto_en = 1'b0;

        req(1'b0, 1'b0, 1'b1, 3'd3, 1'b0);
        chk("rst_pre", 6'b000010, 3'd1, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_pend", 6'b000001, 3'd0, 1'b0);
        fs_pulse();
        chk("rst_discard", 6'b000001, 3'd0, 1'b0);

        req(1'b0, 1'b0, 1'b1, 3'd2, 1'b0);
        fs_pulse();
        chk("sel2_direct", 6'b000100, 3'd2, 1'b0);
        fs_pulse();
        chk("sel2_hold", 6'b000100, 3'd2, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
